// File: rtl/sap_controller.sv
// sap_controller: SAP-1 style ring-counter control sequencer with halt and instruction counting
module sap_controller #(
    parameter logic [3:0] HLT_OP = 4'hF,
    parameter logic [3:0] OUT_OP = 4'hE
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] opcode,
    output logic [5:0] ring,
    output logic       halted,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       mar_load,
    output logic       rom_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       acc_load,
    output logic       acc_out,
    output logic       b_load,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       out_load,
    output logic [7:0] instr_count
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [5:0] ring_q, ring_d;
    logic [7:0] cnt_q, cnt_d;
    logic       step_q, step_d;
    logic       step_rise, is_hlt, is_out, is_lda, is_add, is_sub, is_mem;

    assign step_rise = step & ~step_q;
    assign is_hlt    = opcode == HLT_OP;
    assign is_out    = opcode == OUT_OP & ~is_hlt;
    assign is_lda    = opcode == 4'd0 & ~is_hlt & ~is_out;
    assign is_add    = opcode == 4'd1 & ~is_hlt & ~is_out;
    assign is_sub    = opcode == 4'd2 & ~is_hlt & ~is_out;
    assign is_mem    = is_lda | is_add | is_sub;

    // Next-state: fetch/execute ring advance, halt entry and instruction counting
    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        cnt_d   = cnt_q;
        step_d  = step;
        case (state_q)
            IDLE: begin
                if (run || step_rise) begin
                    state_d = FETCH;
                    ring_d  = 6'b000001;
                end
            end
            FETCH: begin
                ring_d  = ring_q << 1;
                state_d = ring_q[2] ? EXEC : FETCH;
            end
            EXEC: begin
                if (ring_q[3] && is_hlt) begin
                    state_d = HALT;
                    ring_d  = 6'b0;
                    cnt_d   = cnt_q + 8'd1;
                end else if (ring_q[5]) begin
                    state_d = run ? FETCH : IDLE;
                    ring_d  = run ? 6'b000001 : 6'b0;
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    ring_d  = ring_q << 1;
                end
            end
            default: ;
        endcase
    end

    // State registers; clr drops everything back to IDLE without waiting for a clock
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            ring_q  <= 6'b0;
            cnt_q   <= 8'd0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
        end
    end

    // Strobes decode straight from the ring, so IDLE/HALT (ring=0) yield all zeros
    always_comb begin
        pc_out   = ring_q[0];
        pc_inc   = ring_q[1];
        mar_load = ring_q[0] | (ring_q[3] & is_mem);
        rom_out  = ring_q[2] | (ring_q[4] & is_mem);
        ir_load  = ring_q[2];
        ir_out   = ring_q[3] & is_mem;
        acc_out  = ring_q[3] & is_out;
        out_load = ring_q[3] & is_out;
        b_load   = ring_q[4] & (is_add | is_sub);
        acc_load = (ring_q[4] & is_lda) | (ring_q[5] & (is_add | is_sub));
        alu_out  = ring_q[5] & (is_add | is_sub);
        alu_sub  = ring_q[5] & is_sub;
    end

    assign ring        = ring_q;
    assign halted      = state_q == HALT;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_sap_controller.sv
// tb_sap_controller: directed scoreboard bench for sap_controller
module tb_sap_controller;
    logic       clk, clr, run, step;
    logic [3:0] opcode;
    logic [5:0] ring;
    logic       halted, pc_out, pc_inc, mar_load, rom_out, ir_load, ir_out;
    logic       acc_load, acc_out, b_load, alu_out, alu_sub, out_load;
    logic [7:0] instr_count;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_cnt;
    logic [26:0] sb[$];

    sap_controller dut (
        .clk(clk), .clr(clr), .run(run), .step(step), .opcode(opcode),
        .ring(ring), .halted(halted),
        .pc_out(pc_out), .pc_inc(pc_inc), .mar_load(mar_load), .rom_out(rom_out),
        .ir_load(ir_load), .ir_out(ir_out), .acc_load(acc_load), .acc_out(acc_out),
        .b_load(b_load), .alu_out(alu_out), .alu_sub(alu_sub), .out_load(out_load),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe order: pc_out pc_inc mar_load rom_out ir_load ir_out acc_load acc_out b_load alu_out alu_sub out_load
    function automatic logic [11:0] exp_strb(input int t, input logic [3:0] op);
        case (t)
            0: return 12'b1010_0000_0000;
            1: return 12'b0100_0000_0000;
            2: return 12'b0001_1000_0000;
            3: return (op <= 4'd2) ? 12'b0010_0100_0000 : (op == 4'hE) ? 12'b0000_0001_0001 : 12'b0;
            4: return (op == 4'd0) ? 12'b0001_0010_0000 : (op == 4'd1 || op == 4'd2) ? 12'b0001_0000_1000 : 12'b0;
            5: return (op == 4'd1) ? 12'b0000_0010_0100 : (op == 4'd2) ? 12'b0000_0010_0110 : 12'b0;
            default: return 12'b0;
        endcase
    endfunction

    task automatic push(input logic [5:0] r, input logic [11:0] s, input logic [7:0] c, input logic h);
        sb.push_back({r, s, c, h});
    endtask

    task automatic chk(input string tag);
        logic [26:0] obs, exp;
        obs = {ring, pc_out, pc_inc, mar_load, rom_out, ir_load, ir_out, acc_load, acc_out,
               b_load, alu_out, alu_sub, out_load, instr_count, halted};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty obs=%h", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s obs=%h exp=%h (ring/strobes/count/halted)", tag, obs, exp);
            end
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        #1;
        chk(tag);
    endtask

    task automatic run_instr(input logic [3:0] op, input int drop, input string tag);
        opcode = op;
        for (int t = 0; t < 6; t++) begin
            push(6'b1 << t, exp_strb(t, op), exp_cnt, 1'b0);
            cyc(tag);
            if (t == drop) run = 1'b0;
        end
        exp_cnt++;
    endtask

    // Bus exclusivity on every cycle
    always @(negedge clk) begin
        total++;
        assert ($countones({pc_out, rom_out, ir_out, acc_out, alu_out}) <= 1) else begin
            bad++;
            $error("FAIL bus_excl obs=%b exp=at most one driver", {pc_out, rom_out, ir_out, acc_out, alu_out});
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 1'b0; run = 1'b0; step = 1'b0; opcode = 4'd0; exp_cnt = 8'd0;
        #3;
        push(6'b0, 12'b0, 8'd0, 1'b0); chk("reset");
        @(posedge clk); #1;
        push(6'b0, 12'b0, 8'd0, 1'b0); chk("reset_hold");
        clr = 1'b1; run = 1'b1;
        #2;
        push(6'b0, 12'b0, 8'd0, 1'b0); chk("post_release");
        run_instr(4'd0, -1, "prog_lda");
        run_instr(4'd1, -1, "prog_add");
        run_instr(4'd2, -1, "prog_sub");
        run_instr(4'hE, -1, "prog_out");
        opcode = 4'hF;
        for (int t = 0; t < 4; t++) begin
            push(6'b1 << t, exp_strb(t, 4'hF), exp_cnt, 1'b0);
            cyc("prog_hlt");
        end
        exp_cnt++;
        push(6'b0, 12'b0, exp_cnt, 1'b1); cyc("halt_enter");
        for (int i = 0; i < 4; i++) begin
            step = ~step;
            push(6'b0, 12'b0, 8'd5, 1'b1); cyc("halt_hold");
        end
        clr = 1'b0; run = 1'b0; step = 1'b0;
        #1;
        push(6'b0, 12'b0, 8'd0, 1'b0); chk("halt_reset");
        exp_cnt = 8'd0;
        @(posedge clk); #1;
        clr = 1'b1;
        step = 1'b1;
        run_instr(4'd1, -1, "step_add");
        for (int i = 0; i < 4; i++) begin
            push(6'b0, 12'b0, 8'd1, 1'b0); cyc("step_held");
        end
        step = 1'b0;
        push(6'b0, 12'b0, 8'd1, 1'b0); cyc("step_low");
        run = 1'b1;
        run_instr(4'd0, 1, "drop_lda");
        push(6'b0, 12'b0, 8'd2, 1'b0); cyc("drop_idle");
        push(6'b0, 12'b0, 8'd2, 1'b0); cyc("drop_idle2");
        run = 1'b1; opcode = 4'd2;
        for (int t = 0; t < 5; t++) begin
            push(6'b1 << t, exp_strb(t, 4'd2), exp_cnt, 1'b0);
            cyc("midop_sub");
        end
        #2 clr = 1'b0;
        #1;
        push(6'b0, 12'b0, 8'd0, 1'b0); chk("midop_reset");
        exp_cnt = 8'd0; run = 1'b0;
        @(posedge clk); #1;
        push(6'b0, 12'b0, 8'd0, 1'b0); chk("in_reset");
        clr = 1'b1; run = 1'b1;
        for (int i = 0; i < 256; i++) run_instr(4'h7, (i == 255) ? 5 : -1, "nop");
        push(6'b0, 12'b0, 8'd0, 1'b0); cyc("wrap_idle");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sap_controller.md
SAP_CONTROLLER -- requirements
Module: sap_controller

Interface
REQ-001 Parameter HLT_OP, default 4'hF: opcode that halts the machine.
REQ-002 Parameter OUT_OP, default 4'hE: opcode that copies the accumulator to the output register.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 clr  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; 1 = free-running instruction execution.
REQ-006 step  input  1  single-step request, rising-edge detected internally.
REQ-007 opcode  input  4  instruction register upper nibble; valid from T4 onward.
REQ-008 ring  output  6  one-hot T-state T1..T6 (bit0 = T1); 6'b0 when idle or halted.
REQ-009 halted  output  1  1 while in HALT state.
REQ-010 pc_out, pc_inc, mar_load, rom_out, ir_load, ir_out, acc_load, acc_out, b_load, alu_out, alu_sub, out_load  output  1 each  active-high datapath strobes.
REQ-011 instr_count  output  8  number of completed instructions.

Function
REQ-012 States SHALL be IDLE, FETCH (T1-T3), EXEC (T4-T6) and HALT; ring reflects the current T-state.
REQ-013 IDLE -> T1 on a posedge with run=1, or on the first posedge after a detected step rising edge; run takes priority if both are present.
REQ-014 Step edge detection SHALL use a registered copy of step; an edge seen outside IDLE is discarded.
REQ-015 T1: pc_out, mar_load.  T2: pc_inc.  T3: rom_out, ir_load.
REQ-016 T4, opcodes 0/1/2 (LDA/ADD/SUB): ir_out, mar_load.  OUT_OP: acc_out, out_load.  HLT_OP: no strobes; next state HALT.
REQ-017 T5, LDA: rom_out, acc_load.  ADD/SUB: rom_out, b_load.
REQ-018 T6, ADD: alu_out, acc_load.  SUB: alu_out, acc_load, alu_sub.
REQ-019 Any other opcode SHALL execute as NOP: T4-T6 are traversed with no strobes.
REQ-020 Strobes SHALL be combinational from ring and opcode; all strobes are 0 in IDLE and HALT.
REQ-021 At most one of pc_out, rom_out, ir_out, acc_out, alu_out SHALL be asserted in any cycle (bus exclusivity).
REQ-022 After T6: go to T1 if run=1, otherwise to IDLE.
REQ-023 Deasserting run mid-instruction SHALL NOT abort it; the instruction completes through T6, then the controller goes to IDLE.
REQ-024 A step-started instruction SHALL return to IDLE after T6 unless run=1 at that edge.
REQ-025 instr_count SHALL increment by 1 on the T6 -> next-state edge and on the T4 -> HALT edge.
REQ-026 instr_count SHALL wrap from 255 to 0.
REQ-027 HALT SHALL be exited only by reset; run and step are ignored while halted.
REQ-028 Instruction latency SHALL be exactly 6 clocks, T1 through T6; there are no bubbles between consecutive instructions while run=1.

Reset
REQ-029 clr=0 SHALL immediately force IDLE, ring=0, halted=0, all strobes 0, instr_count=0 and the step history register to 0, independent of clk.
REQ-030 Reset asserted mid-instruction SHALL abandon that instruction without incrementing instr_count.
REQ-031 After clr rises, the first state change SHALL occur no earlier than the next posedge clk.

Verification
REQ-032 Run program: run=1 with opcodes 0,1,2,E,F -> ring cycles T1..T6 per instruction; strobes match REQ-015..018 each cycle; instr_count=5 and halted=1 after the HLT T4 edge.
REQ-033 Step: run=0, step pulse, opcode=1 -> exactly one 6-cycle ADD, then IDLE with instr_count=1; holding step high produces no second instruction.
REQ-034 run drop: deassert run at T2 of an LDA -> T3..T6 complete, then IDLE and ring=0.
REQ-035 Reset mid-op: clr=0 at T5 of a SUB -> ring=0 and instr_count=0 within the same cycle, with no clock edge required.
REQ-036 Wrap and NOP: 256 NOPs (opcode 4'h7) under run=1 -> instr_count wraps 255 -> 0; no strobes asserted in T4-T6.
REQ-037 Every bench SHALL check the bus-exclusivity assertion (REQ-021) on every cycle.
